// File: rtl/fwd_hazard_ctrl.sv
// EX forwarding-select and ID-stall control: selects/ex_first/ex_busy are registered (1 cycle), stall_id is combinational.
// Backpressure: stall_id holds ID for a load-use bubble or while a multicycle op owns EX; flush overrides both.
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic [LAT_W-1:0] id_mc_lat,
  input  logic             flush,
  output logic             stall_id,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             ex_first,
  output logic             ex_busy
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             is_load;
  } slot_t;

  typedef enum logic {RUN, BUSY} state_e;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  // A producer already in WB retires before the consumer reaches EX, so
  // only EX and MEM occupancy can ever influence a select or a stall.
  slot_t            ex_q, ex_d, mem_q, mem_d;
  slot_t            id_slot;
  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic             ex_first_q, ex_first_d;
  logic             busy, load_use;
  logic [1:0]       sel_a, sel_b;

  function automatic logic writes(input slot_t s, input logic [REG_W-1:0] rs);
    return s.valid && s.we && (s.rd != '0) && (s.rd == rs);
  endfunction

  function automatic logic [1:0] pick(input slot_t ex, input slot_t mem,
                                      input logic [REG_W-1:0] rs);
    if (writes(ex, rs))       return SEL_MEM;
    else if (writes(mem, rs)) return SEL_WB;
    else                      return SEL_RF;
  endfunction

  always_comb begin
    id_slot         = '0;
    id_slot.valid   = id_valid;
    id_slot.rd      = id_rd;
    id_slot.we      = id_we;
    id_slot.is_load = id_is_load;
    if (!id_valid) id_slot = '0;

    busy     = (state_q == BUSY);
    load_use = id_valid && ex_q.valid && ex_q.is_load &&
               (writes(ex_q, id_rs1) || writes(ex_q, id_rs2));
    stall_id = busy || load_use;
    sel_a    = pick(ex_q, mem_q, id_rs1);
    sel_b    = pick(ex_q, mem_q, id_rs2);
  end

  always_comb begin
    ex_d       = ex_q;
    mem_d      = busy ? slot_t'('0) : ex_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    fwd_a_d    = fwd_a_q;
    fwd_b_d    = fwd_b_q;
    ex_first_d = 1'b0;

    if (flush) begin
      ex_d    = '0;
      cnt_d   = '0;
      state_d = RUN;
      fwd_a_d = SEL_RF;
      fwd_b_d = SEL_RF;
    end else if (busy) begin
      // EX residency is N+1 cycles: leave BUSY once the count reaches 1.
      cnt_d = (cnt_q != '0) ? cnt_q - LAT_W'(1) : '0;
      if (cnt_q <= LAT_W'(1)) state_d = RUN;
    end else if (load_use) begin
      ex_d    = '0;
      fwd_a_d = SEL_RF;
      fwd_b_d = SEL_RF;
    end else begin
      ex_d       = id_slot;
      fwd_a_d    = id_valid ? sel_a : SEL_RF;
      fwd_b_d    = id_valid ? sel_b : SEL_RF;
      ex_first_d = id_valid;
      if (id_valid && (id_mc_lat != '0)) begin
        cnt_d   = id_mc_lat;
        state_d = BUSY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      mem_q      <= '0;
      state_q    <= RUN;
      cnt_q      <= '0;
      fwd_a_q    <= SEL_RF;
      fwd_b_q    <= SEL_RF;
      ex_first_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      ex_first_q <= ex_first_d;
    end
  end

  assign fwd_a    = fwd_a_q;
  assign fwd_b    = fwd_b_q;
  assign ex_first = ex_first_q;
  assign ex_busy  = (state_q == BUSY);

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Pipeline-control stage directly upstream of the operand-select muxes in the EX stage.
- Tracks destination registers of in-flight instructions (EX/MEM/WB) and produces registered 2-bit forwarding selects per EX operand, encoded for the 3-input mux: 00=regfile, 10=MEM result, 11=WB result.
- Also generates the ID stall for load-use hazards and for multicycle EX operations (FPU/div), using an internal busy counter.

Parameters:
- REG_W, 5, register-address width.
- LAT_W, 4, width of multicycle extra-latency field.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_W  source 1 address
- id_rs2  in  REG_W  source 2 address
- id_rd  in  REG_W  destination address
- id_we  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load (result available at end of MEM)
- id_mc_lat  in  LAT_W  extra EX cycles (0 = single-cycle)
- flush  in  1  kill ID and EX contents (branch redirect)
- stall_id  out  1  hold PC/IF/ID this cycle (combinational)
- fwd_a  out  2  EX operand-A mux select (registered)
- fwd_b  out  2  EX operand-B mux select (registered)
- ex_first  out  1  first cycle of the current EX instruction; datapath latches operands only then (registered)
- ex_busy  out  1  EX held by a multicycle op (registered)

Behaviour:
- Internal slots EX, MEM, WB each hold {valid, rd, we, is_load}; MEM/WB advance every cycle unconditionally.
- Reset (async, rst_n=0): all slots invalid, counter=0, FSM=RUN, fwd_a=fwd_b=00, ex_first=0, ex_busy=0; stall_id=0 while in reset.
- Writer match: slot valid & we & rd!=0 & rd==rs. x0 never forwarded and never stalls.
- Select (computed in ID vs current slots): EX match -> 10; else MEM match -> 11; else 00. EX takes priority when both match.
- Load-use: ID valid & EX slot is_load & EX match on rs1 or rs2 -> stall_id=1 for one cycle; next cycle load is in MEM, select becomes 11.
- FSM RUN: if no stall, ID moves into EX (fwd_*, ex_first=1 registered); if stalled, bubble into EX (fwd_*=00, ex_first=0).
- On EX entry with id_mc_lat=N>0: counter<=N, FSM->BUSY.
- FSM BUSY: EX slot held, MEM receives bubble, stall_id=1, ex_busy=1, ex_first=0, fwd_* hold value; counter decrements each cycle; when counter==1 -> RUN next cycle (EX residency N+1 cycles total; EX advances into MEM on the RUN cycle).
- Selects are re-evaluated every cycle while ID stalls, so producers draining from MEM/WB are tracked.
- stall_id = BUSY | load-use (combinational from slots and ID inputs).
- flush (priority over stall and BUSY): next cycle EX slot invalid, counter=0, FSM=RUN, fwd_*=00, ex_first=0, ex_busy=0. MEM/WB unaffected; the instruction leaving EX that cycle still enters MEM unless FSM was BUSY.
- id_valid=0: treated as bubble; no stall contribution from it.
- Counter saturates at 0; id_mc_lat ignored when id_valid=0.

Test Plan:
- Back-to-back ALU: add x5 then sub x6,x5,x5 -> stall_id=0; next cycle fwd_a=fwd_b=10, ex_first=1.
- Distance-2: add x5; nop; or x7,x5,x1 -> fwd_a=11, fwd_b=00; producer in EX and MEM both writing x5 -> 10 chosen.
- Load-use: lw x3; add x4,x3,x2 -> stall_id=1 exactly 1 cycle, EX bubble (fwd 00), then fwd_a=11.
- Multicycle: fdiv with id_mc_lat=3 followed by dependent op -> ex_busy=1 for 3 cycles, stall_id=1 for those 3 cycles, then consumer gets fwd=10.
- x0 and flush: writer rd=0 with reader rs1=0 -> fwd_a=00, no stall; flush during BUSY (counter=2) -> next cycle ex_busy=0, stall_id=0, ex_first=0.
- Async reset asserted mid-BUSY, no clock edge -> all outputs 0 immediately; after release, first instruction issues with no stall.
